systolic_array_ctrl: RTL and testbench
======================================

SYSTOLIC_ARRAY_CTRL -- requirements
Module: systolic_array_ctrl

Interface
REQ-001 Parameter ARRAY_SIZE, default 4: array dimension N; legal range 2..8.
REQ-002 Parameter DATA_WIDTH, default 8: operand width per lane.
REQ-003 clk  in  1  single system clock; all state changes on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  request a multiply; sampled only in IDLE.
REQ-006 abort  in  1  cancel the current run; no done pulse.
REQ-007 busy  out  1  high in every state except IDLE.
REQ-008 done  out  1  one-cycle pulse when results are stable.
REQ-009 buf_rd_en  out  1  read strobe to the A and B operand buffers.
REQ-010 buf_rd_addr  out  clog2(N)  k index: column k of A, row k of B.
REQ-011 a_col_data  in  N*DATA_WIDTH  A column; lane i = A[i][k]; 1-cycle read latency.
REQ-012 b_row_data  in  N*DATA_WIDTH  B row; lane j = B[k][j]; 1-cycle read latency.
REQ-013 array_a  out  N*DATA_WIDTH  skewed left-edge operands, lane i to row i.
REQ-014 array_b  out  N*DATA_WIDTH  skewed top-edge operands, lane j to column j.
REQ-015 array_en  out  1  array MAC/shift enable.
REQ-016 array_clr  out  1  clear all PE accumulators and pipeline registers.

Function
REQ-017 The FSM SHALL have the states IDLE, CLEAR, FEED, FLUSH and DONE, with a counter cnt of width clog2(3N).
REQ-018 IDLE: start=1 -> CLEAR; otherwise stay.
REQ-019 CLEAR lasts one cycle with array_clr=1 and cnt set to 0; next state FEED.
REQ-020 FEED: buf_rd_en=1, buf_rd_addr=cnt, cnt increments; when cnt==N-1 -> FLUSH.
REQ-021 FLUSH: buf_rd_en=0, cnt increments; when cnt==3N-2 -> DONE.
REQ-022 array_en SHALL be 1 in FEED and FLUSH only.
REQ-023 Skew: lane i of both buses is delayed i cycles after read data returns (lane 0 passes through combinationally).
REQ-024 Any lane value that does not originate from a FEED read SHALL be zero, so that zero-padding never alters accumulators.
REQ-025 Operands are forwarded unchanged; the block performs no arithmetic on them.
REQ-026 DONE lasts one cycle with done=1, then returns to IDLE.
REQ-027 Latency: done SHALL occur exactly 3N+1 cycles after the edge on which start is accepted (13 cycles for N=4).
REQ-028 start is ignored outside IDLE, including in DONE; a start held high re-triggers only from IDLE.
REQ-029 abort=1 in CLEAR, FEED or FLUSH SHALL move the FSM to IDLE on the next edge, with no done pulse and the skew registers zeroed.
REQ-030 abort in IDLE or DONE SHALL have no effect; when abort and start are both high in IDLE, start wins.
REQ-031 array_a and array_b SHALL be all-zero in IDLE, CLEAR and DONE.

Reset
REQ-032 On reset=1 at a clock edge, the FSM SHALL enter IDLE and cnt and all skew registers SHALL clear to 0.
REQ-033 The reset values of busy, done, buf_rd_en, buf_rd_addr, array_en, array_clr, array_a and array_b SHALL all be 0.
REQ-034 Reset during an active run SHALL behave as abort plus register clear; the next start SHALL begin a clean run.

Structure
REQ-035 The FSM state enum and the default ARRAY_SIZE and DATA_WIDTH SHALL live in the shared package sa_pkg.
REQ-036 The triangular delay line SHALL be one sub-module, skew_buffer, parameterised by N and DATA_WIDTH, with a synchronous clear.
REQ-037 The controller SHALL instantiate skew_buffer twice, once for A and once for B.
REQ-038 The controller SHALL contain no multipliers.

Verification
REQ-039 N=4, A=B=identity, start pulse -> exactly one done pulse 13 cycles later, and the reference array model yields C = identity.
REQ-040 N=4, A[i][k]=i+k+1 and B=all-ones -> array_a lane 3 first nonzero exactly 3 cycles after lane 0; every C row i equals the A row-i sum.
REQ-041 abort asserted on FEED cnt=2 -> IDLE next cycle, busy=0, no done pulse, array_a and array_b zero; a following start gives a correct result.
REQ-042 start held high continuously -> back-to-back runs with a done every 14 cycles, and array_clr asserted once per run.
REQ-043 reset pulsed during FLUSH -> all outputs 0 on the next cycle; start accepted immediately afterwards.
REQ-044 N=2, max operand 8'hFF everywhere -> done after 7 cycles, and buf_rd_addr sequence 0,1 only.

Source files
------------

// File: rtl/systolic_array_ctrl_pkg.sv
// Shared types and defaults for the systolic array controller.
// Holds the FSM state encoding and the default array geometry.
package sa_pkg;

  localparam int DEF_ARRAY_SIZE = 4;
  localparam int DEF_DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    FLUSH,
    DONE
  } sa_state_e;

endpackage

// File: rtl/systolic_array_ctrl_if.sv
// Control, operand-buffer and array-edge bundle of the controller.
// master is the controller side, slave the host/buffer/array side.
interface systolic_array_ctrl_if
  import sa_pkg::*;
#(
  parameter int N  = DEF_ARRAY_SIZE,
  parameter int DW = DEF_DATA_WIDTH
) ();

  localparam int AW = $clog2(N);

  logic            start;
  logic            abort;
  logic            busy;
  logic            done;
  logic            buf_rd_en;
  logic [AW-1:0]   buf_rd_addr;
  logic [N*DW-1:0] a_col_data;
  logic [N*DW-1:0] b_row_data;
  logic [N*DW-1:0] array_a;
  logic [N*DW-1:0] array_b;
  logic            array_en;
  logic            array_clr;

  modport master (
    input  start, abort,
    input  a_col_data, b_row_data,
    output busy, done,
    output buf_rd_en, buf_rd_addr,
    output array_a, array_b,
    output array_en, array_clr
  );

  modport slave (
    output start, abort,
    output a_col_data, b_row_data,
    input  busy, done,
    input  buf_rd_en, buf_rd_addr,
    input  array_a, array_b,
    input  array_en, array_clr
  );

endinterface

// File: rtl/systolic_array_ctrl_skew_buffer.sv
// Triangular delay line: lane i is delayed by i cycles.
// Lane 0 is a straight wire; clr zeroes every stage.
module skew_buffer
  import sa_pkg::*;
#(
  parameter int N          = DEF_ARRAY_SIZE,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic [N*DATA_WIDTH-1:0] din,
  output logic [N*DATA_WIDTH-1:0] dout
);

  localparam int DW = DATA_WIDTH;

  assign dout[DW-1:0] = din[DW-1:0];

  for (genvar i = 1; i < N; i++) begin : g_lane
    logic [DW-1:0] sr_q [i];
    logic [DW-1:0] sr_d [i];

    always_comb begin
      sr_d[0] = din[i*DW +: DW];
      for (int s = 1; s < i; s++) begin
        sr_d[s] = sr_q[s-1];
      end
    end

    always_ff @(posedge clk) begin
      if (clr) begin
        sr_q <= '{default: '0};
      end else begin
        sr_q <= sr_d;
      end
    end

    assign dout[i*DW +: DW] = sr_q[i-1];
  end

endmodule

// File: rtl/systolic_array_ctrl.sv
// Sequencer for an NxN output-stationary systolic array:
// reads operand buffers, skews the edges and reports completion.
module systolic_array_ctrl
  import sa_pkg::*;
#(
  parameter int ARRAY_SIZE = DEF_ARRAY_SIZE,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input logic                   clk,
  input logic                   reset,
  systolic_array_ctrl_if.master bus
);

  localparam int N  = ARRAY_SIZE;
  localparam int DW = DATA_WIDTH;
  localparam int AW = $clog2(N);
  localparam int CW = $clog2(3*N);

  localparam logic [CW-1:0] FEED_END  = CW'(N-1);
  localparam logic [CW-1:0] FLUSH_END = CW'(3*N-2);

  sa_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          rd_en_q, rd_en_d;
  logic          en_q, en_d;
  logic          clr_q, clr_d;
  logic          vld_q, vld_d;

  logic            abort_hit;
  logic            skew_clr;
  logic [N*DW-1:0] a_lane, b_lane;
  logic [N*DW-1:0] a_skew, b_skew;

  assign abort_hit = bus.abort &
    (state_q inside {CLEAR, FEED, FLUSH});

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.start) state_d = CLEAR;
      end
      CLEAR: begin
        cnt_d   = '0;
        state_d = FEED;
      end
      FEED: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == FEED_END) state_d = FLUSH;
      end
      FLUSH: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == FLUSH_END) state_d = DONE;
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
    if (abort_hit) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  // Outputs decode the next state so they line up with state_q.
  always_comb begin
    busy_d  = state_d != IDLE;
    done_d  = state_d == DONE;
    rd_en_d = state_d == FEED;
    addr_d  = rd_en_d ? cnt_d[AW-1:0] : '0;
    en_d    = state_d inside {FEED, FLUSH};
    clr_d   = state_d == CLEAR;
    vld_d   = rd_en_q & ~abort_hit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      en_q    <= 1'b0;
      clr_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rd_en_q <= rd_en_d;
      en_q    <= en_d;
      clr_q   <= clr_d;
      vld_q   <= vld_d;
    end
  end

  // Buffer data is only trusted the cycle after a FEED read.
  assign a_lane   = vld_q ? bus.a_col_data : '0;
  assign b_lane   = vld_q ? bus.b_row_data : '0;
  assign skew_clr = reset | abort_hit | clr_q;

  skew_buffer #(
    .N          (N),
    .DATA_WIDTH (DW)
  ) u_skew_a (
    .clk  (clk),
    .clr  (skew_clr),
    .din  (a_lane),
    .dout (a_skew)
  );

  skew_buffer #(
    .N          (N),
    .DATA_WIDTH (DW)
  ) u_skew_b (
    .clk  (clk),
    .clr  (skew_clr),
    .din  (b_lane),
    .dout (b_skew)
  );

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.buf_rd_en   = rd_en_q;
  assign bus.buf_rd_addr = addr_q;
  assign bus.array_en    = en_q;
  assign bus.array_clr   = clr_q;
  assign bus.array_a     = en_q ? a_skew : '0;
  assign bus.array_b     = en_q ? b_skew : '0;

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Bench for systolic_array_ctrl: N=4 and N=2 instances with
// buffer models, a reference PE-grid model and a result scoreboard.
module tb_systolic_array_ctrl;

  typedef logic [3:0][3:0][31:0] mat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start4 = 1'b0;
  logic start2 = 1'b0;
  logic abort = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  systolic_array_ctrl_if #(.N(4), .DW(8)) bus4 ();
  systolic_array_ctrl_if #(.N(2), .DW(8)) bus2 ();

  systolic_array_ctrl #(
    .ARRAY_SIZE (4),
    .DATA_WIDTH (8)
  ) dut4 (
    .clk   (clk),
    .reset (rst),
    .bus   (bus4)
  );

  systolic_array_ctrl #(
    .ARRAY_SIZE (2),
    .DATA_WIDTH (8)
  ) dut2 (
    .clk   (clk),
    .reset (rst),
    .bus   (bus2)
  );

  logic [31:0] a4, b4;
  logic [15:0] a2, b2;

  assign bus4.start      = start4;
  assign bus4.abort      = abort;
  assign bus4.a_col_data = a4;
  assign bus4.b_row_data = b4;
  assign bus2.start      = start2;
  assign bus2.abort      = abort;
  assign bus2.a_col_data = a2;
  assign bus2.b_row_data = b2;

  logic [70:0] o4;
  logic [37:0] o2;
  assign o4 = {bus4.busy, bus4.done, bus4.buf_rd_en,
               bus4.buf_rd_addr, bus4.array_en,
               bus4.array_clr, bus4.array_a, bus4.array_b};
  assign o2 = {bus2.busy, bus2.done, bus2.buf_rd_en,
               bus2.buf_rd_addr, bus2.array_en,
               bus2.array_clr, bus2.array_a, bus2.array_b};

  // Operand buffers: garbage on the bus whenever no read was issued.
  logic [7:0] ma [4][4];
  logic [7:0] mb [4][4];

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (bus4.buf_rd_en) begin
        a4[i*8 +: 8] <= ma[i][bus4.buf_rd_addr];
        b4[i*8 +: 8] <= mb[bus4.buf_rd_addr][i];
      end else begin
        a4[i*8 +: 8] <= 8'($urandom_range(1, 255));
        b4[i*8 +: 8] <= 8'($urandom_range(1, 255));
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (bus2.buf_rd_en) begin
        a2[i*8 +: 8] <= ma[i][bus2.buf_rd_addr];
        b2[i*8 +: 8] <= mb[bus2.buf_rd_addr][i];
      end else begin
        a2[i*8 +: 8] <= 8'($urandom_range(1, 255));
        b2[i*8 +: 8] <= 8'($urandom_range(1, 255));
      end
    end
  end

  // Reference output-stationary PE grid driven by the DUT edges.
  logic [31:0] av [2];
  logic [31:0] bv [2];
  logic        men [2];
  logic        mclr [2];
  assign av[0]   = bus4.array_a;
  assign bv[0]   = bus4.array_b;
  assign av[1]   = {16'h0, bus2.array_a};
  assign bv[1]   = {16'h0, bus2.array_b};
  assign men[0]  = bus4.array_en;
  assign men[1]  = bus2.array_en;
  assign mclr[0] = bus4.array_clr;
  assign mclr[1] = bus2.array_clr;

  int unsigned acc [2][4][4];
  logic [7:0]  pa  [2][4][4];
  logic [7:0]  pb  [2][4][4];
  logic [7:0]  ain [2][4][4];
  logic [7:0]  bin [2][4][4];

  always_comb begin
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) begin
        for (int j = 0; j < 4; j++) begin
          ain[d][i][j] = (j == 0) ? av[d][i*8 +: 8]
                       : pa[d][i][(j == 0) ? 0 : j-1];
          bin[d][i][j] = (i == 0) ? bv[d][j*8 +: 8]
                       : pb[d][(i == 0) ? 0 : i-1][j];
        end
      end
    end
  end

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) begin
        for (int j = 0; j < 4; j++) begin
          if (mclr[d]) begin
            acc[d][i][j] <= 0;
            pa[d][i][j]  <= '0;
            pb[d][i][j]  <= '0;
          end else if (men[d]) begin
            acc[d][i][j] <= acc[d][i][j] +
              32'(ain[d][i][j]) * 32'(bin[d][i][j]);
            pa[d][i][j] <= ain[d][i][j];
            pb[d][i][j] <= bin[d][i][j];
          end
        end
      end
    end
  end

  mat_t exp4_q[$];
  mat_t exp2_q[$];

  function automatic mat_t ref_mul(input int n);
    mat_t r = '0;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++)
        for (int k = 0; k < n; k++)
          r[i][j] += 32'(ma[i][k]) * 32'(mb[k][j]);
    return r;
  endfunction

  function automatic mat_t model_c(input int d);
    mat_t r;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        r[i][j] = acc[d][i][j];
    return r;
  endfunction

  task automatic load(input int kind);
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        case (kind)
          0: begin
            ma[i][j] = (i == j) ? 8'd1 : 8'd0;
            mb[i][j] = (i == j) ? 8'd1 : 8'd0;
          end
          1: begin
            ma[i][j] = 8'(i + j + 1);
            mb[i][j] = 8'd1;
          end
          2: begin
            ma[i][j] = 8'hFF;
            mb[i][j] = 8'hFF;
          end
          default: begin
            ma[i][j] = 8'($urandom_range(0, 255));
            mb[i][j] = 8'($urandom_range(0, 255));
          end
        endcase
      end
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((bus4.busy || bus2.busy) && t < 200) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (bus4.busy || bus2.busy) begin
      errors++;
      $display("FAIL idle_timeout: busy4=%b busy2=%b want 0 0",
               bus4.busy, bus2.busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start4 = 1'b0;
    start2 = 1'b0;
    abort = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (o4 !== '0) begin
      errors++;
      $display("FAIL reset_n4: outputs=%h want 0", o4);
    end
    checks++;
    if (o2 !== '0) begin
      errors++;
      $display("FAIL reset_n2: outputs=%h want 0", o2);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (o4 !== '0) begin
      errors++;
      $display("FAIL idle_quiet: outputs=%h want 0", o4);
    end
  endtask

  task automatic test_identity();
    int done_at = 0;
    int ndone = 0;
    mat_t em, got;
    load(0);
    exp4_q.push_back(ref_mul(4));
    @(negedge clk);
    start4 = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start4 = 1'b0;
        checks++;
        if (bus4.array_clr !== 1'b1 || bus4.array_a !== '0) begin
          errors++;
          $display("FAIL clear_cycle: clr=%b a=%h want 1 0",
                   bus4.array_clr, bus4.array_a);
        end
      end
      if (bus4.done === 1'b1) begin
        ndone++;
        if (done_at == 0) done_at = c;
        checks++;
        if (bus4.array_a !== '0 || bus4.array_b !== '0) begin
          errors++;
          $display("FAIL done_zero: a=%h b=%h want 0",
                   bus4.array_a, bus4.array_b);
        end
        checks++;
        if (exp4_q.size() == 0) begin
          errors++;
          $display("FAIL c_identity: done with no expected result");
        end else begin
          em = exp4_q.pop_front();
          got = model_c(0);
          if (got !== em) begin
            errors++;
            $display("FAIL c_identity: got %h want %h", got, em);
          end
        end
      end
    end
    checks++;
    if (done_at != 13) begin
      errors++;
      $display("FAIL lat_identity: done at %0d want 13", done_at);
    end
    checks++;
    if (ndone != 1) begin
      errors++;
      $display("FAIL ndone_identity: %0d pulses want 1", ndone);
    end
  endtask

  task automatic test_skew();
    int first0 = 0;
    int first3 = 0;
    int done_at = 0;
    mat_t em, got;
    wait_idle();
    load(1);
    exp4_q.push_back(ref_mul(4));
    @(negedge clk);
    start4 = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      if (c == 1) start4 = 1'b0;
      if (first0 == 0 && bus4.array_a[7:0] != 0) first0 = c;
      if (first3 == 0 && bus4.array_a[31:24] != 0) first3 = c;
      if (bus4.done === 1'b1) begin
        if (done_at == 0) done_at = c;
        checks++;
        if (exp4_q.size() == 0) begin
          errors++;
          $display("FAIL c_skew: done with no expected result");
        end else begin
          em = exp4_q.pop_front();
          got = model_c(0);
          if (got !== em) begin
            errors++;
            $display("FAIL c_skew: got %h want %h", got, em);
          end
        end
      end
    end
    checks++;
    if (first0 != 3) begin
      errors++;
      $display("FAIL lane0_first: cycle %0d want 3", first0);
    end
    checks++;
    if (first3 - first0 != 3) begin
      errors++;
      $display("FAIL lane3_skew: lag %0d want 3", first3 - first0);
    end
    checks++;
    if (done_at != 13) begin
      errors++;
      $display("FAIL lat_skew: done at %0d want 13", done_at);
    end
  endtask

  task automatic test_abort();
    int nd = 0;
    int done_at = 0;
    mat_t em, got;
    wait_idle();
    load(3);
    @(negedge clk);
    start4 = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) start4 = 1'b0;
    end
    checks++;
    if (bus4.buf_rd_en !== 1'b1 || bus4.buf_rd_addr !== 2'd2) begin
      errors++;
      $display("FAIL abort_pre: rd_en=%b addr=%0d want 1 2",
               bus4.buf_rd_en, bus4.buf_rd_addr);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (bus4.busy !== 1'b0 || bus4.array_en !== 1'b0 ||
        bus4.array_a !== '0 || bus4.array_b !== '0) begin
      errors++;
      $display("FAIL abort_idle: busy=%b en=%b a=%h b=%h want 0",
               bus4.busy, bus4.array_en, bus4.array_a, bus4.array_b);
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus4.done === 1'b1) nd++;
    end
    checks++;
    if (nd != 0) begin
      errors++;
      $display("FAIL abort_nodone: %0d pulses want 0", nd);
    end
    load(3);
    exp4_q.push_back(ref_mul(4));
    start4 = 1'b1;
    abort = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start4 = 1'b0;
        abort = 1'b0;
        checks++;
        if (bus4.busy !== 1'b1) begin
          errors++;
          $display("FAIL start_wins: busy=%b want 1", bus4.busy);
        end
      end
      if (bus4.done === 1'b1) begin
        if (done_at == 0) done_at = c;
        checks++;
        if (exp4_q.size() == 0) begin
          errors++;
          $display("FAIL c_after_abort: no expected result");
        end else begin
          em = exp4_q.pop_front();
          got = model_c(0);
          if (got !== em) begin
            errors++;
            $display("FAIL c_after_abort: got %h want %h", got, em);
          end
        end
      end
    end
    checks++;
    if (done_at != 13) begin
      errors++;
      $display("FAIL lat_after_abort: done at %0d want 13", done_at);
    end
  endtask

  task automatic test_back_to_back();
    int dq[$];
    int nclr = 0;
    mat_t em, got;
    wait_idle();
    load(3);
    repeat (3) exp4_q.push_back(ref_mul(4));
    @(negedge clk);
    start4 = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 29) start4 = 1'b0;
      if (bus4.array_clr === 1'b1) nclr++;
      if (bus4.done === 1'b1) begin
        dq.push_back(c);
        checks++;
        if (exp4_q.size() == 0) begin
          errors++;
          $display("FAIL c_b2b: done %0d with no expected result", c);
        end else begin
          em = exp4_q.pop_front();
          got = model_c(0);
          if (got !== em) begin
            errors++;
            $display("FAIL c_b2b: got %h want %h", got, em);
          end
        end
      end
    end
    checks++;
    if (nclr != 3) begin
      errors++;
      $display("FAIL clr_b2b: %0d clears want 3", nclr);
    end
    checks++;
    if (dq.size() != 3) begin
      errors++;
      $display("FAIL ndone_b2b: %0d pulses want 3", dq.size());
    end else begin
      checks++;
      if (dq[0] != 13 || dq[1] - dq[0] != 14 ||
          dq[2] - dq[1] != 14) begin
        errors++;
        $display("FAIL period_b2b: done at %0d %0d %0d want 13 27 41",
                 dq[0], dq[1], dq[2]);
      end
    end
  endtask

  task automatic test_reset_flush();
    int done_at = 0;
    mat_t em, got;
    wait_idle();
    load(3);
    @(negedge clk);
    start4 = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) start4 = 1'b0;
    end
    checks++;
    if (bus4.busy !== 1'b1 || bus4.buf_rd_en !== 1'b0 ||
        bus4.array_en !== 1'b1) begin
      errors++;
      $display("FAIL flush_pre: busy=%b rd=%b en=%b want 1 0 1",
               bus4.busy, bus4.buf_rd_en, bus4.array_en);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (o4 !== '0) begin
      errors++;
      $display("FAIL reset_flush: outputs=%h want 0", o4);
    end
    load(3);
    exp4_q.push_back(ref_mul(4));
    start4 = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start4 = 1'b0;
        checks++;
        if (bus4.busy !== 1'b1 || bus4.array_clr !== 1'b1) begin
          errors++;
          $display("FAIL restart: busy=%b clr=%b want 1 1",
                   bus4.busy, bus4.array_clr);
        end
      end
      if (bus4.done === 1'b1) begin
        if (done_at == 0) done_at = c;
        checks++;
        if (exp4_q.size() == 0) begin
          errors++;
          $display("FAIL c_after_reset: no expected result");
        end else begin
          em = exp4_q.pop_front();
          got = model_c(0);
          if (got !== em) begin
            errors++;
            $display("FAIL c_after_reset: got %h want %h", got, em);
          end
        end
      end
    end
    checks++;
    if (done_at != 13) begin
      errors++;
      $display("FAIL lat_after_reset: done at %0d want 13", done_at);
    end
  endtask

  task automatic test_n2();
    int addrs[$];
    int done_at = 0;
    int ndone = 0;
    mat_t em, got;
    wait_idle();
    load(2);
    exp2_q.push_back(ref_mul(2));
    @(negedge clk);
    start2 = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) start2 = 1'b0;
      if (bus2.buf_rd_en === 1'b1) addrs.push_back(int'(bus2.buf_rd_addr));
      if (bus2.done === 1'b1) begin
        ndone++;
        if (done_at == 0) done_at = c;
        checks++;
        if (exp2_q.size() == 0) begin
          errors++;
          $display("FAIL c_n2: done with no expected result");
        end else begin
          em = exp2_q.pop_front();
          got = model_c(1);
          if (got !== em) begin
            errors++;
            $display("FAIL c_n2: got %h want %h", got, em);
          end
        end
      end
    end
    checks++;
    if (done_at != 7 || ndone != 1) begin
      errors++;
      $display("FAIL lat_n2: done at %0d x%0d want 7 x1",
               done_at, ndone);
    end
    checks++;
    if (addrs.size() != 2 || addrs[0] != 0 || addrs[1] != 1) begin
      errors++;
      $display("FAIL addr_n2: %0d reads %p want 0,1",
               addrs.size(), addrs);
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_skew();
    test_abort();
    test_back_to_back();
    test_reset_flush();
    test_n2();
    wait_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
